// File: rtl/key_cond_pkg.sv
// Shared types and helpers for the key input-conditioning stage.
package key_cond_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_PEND,
        HELD,
        REPEAT,
        RELEASE_PEND
    } key_state_t;

    // Largest debounce length the 8-bit confirmation counter can express.
    localparam int MAX_DEBOUNCE_MS = 255;

    // Number of clock cycles in one millisecond at the given clock rate.
    function automatic int ms_to_cycles(input int clk_mhz);
        return clk_mhz * 1000;
    endfunction

endpackage

// File: rtl/key_channel.sv
// One key channel: debounce FSM with auto-repeat, advancing only on tick cycles.
// Produces the decisions for the next cycle; the top level registers them.
module key_channel
    import key_cond_pkg::*;
#(
    parameter int debounce_ms      = 10,
    parameter int repeat_delay_ms  = 400,
    parameter int repeat_period_ms = 100,
    parameter bit repeat_enable    = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic sample,
    output logic press_now,
    output logic release_now,
    output logic level_next
);

    localparam int HOLD_MAX_MS = (repeat_delay_ms > repeat_period_ms) ? repeat_delay_ms
                                                                      : repeat_period_ms;
    localparam int HOLD_W      = $clog2(HOLD_MAX_MS + 1);
    localparam int DEB_CLAMP   = (debounce_ms < 1) ? 1 :
                                 ((debounce_ms > MAX_DEBOUNCE_MS) ? MAX_DEBOUNCE_MS : debounce_ms);

    localparam logic [7:0]        DEB    = 8'(DEB_CLAMP);
    localparam logic [HOLD_W-1:0] DELAY  = HOLD_W'(repeat_delay_ms);
    localparam logic [HOLD_W-1:0] PERIOD = HOLD_W'(repeat_period_ms);
    localparam logic [HOLD_W-1:0] HOLD_SAT = '1;

    key_state_t        state, state_n;
    logic [7:0]        cnt, cnt_n, cnt_inc;
    logic [HOLD_W-1:0] hold, hold_n, hold_inc, hold_target;
    logic              from_repeat, from_repeat_n;

    // Saturating increments so long holds or long pending phases never wrap.
    assign cnt_inc     = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    assign hold_inc    = (hold == HOLD_SAT) ? hold : hold + 1'b1;
    assign hold_target = (state == HELD) ? DELAY : PERIOD;

    // The debounced level follows the state we are about to enter.
    assign level_next = (state_n == HELD) || (state_n == REPEAT) || (state_n == RELEASE_PEND);

    // State and counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            hold        <= '0;
            from_repeat <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            hold        <= hold_n;
            from_repeat <= from_repeat_n;
        end
    end

    // Next-state logic; release detection is checked before any repeat decision.
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        hold_n        = hold;
        from_repeat_n = from_repeat;
        press_now     = 1'b0;
        release_now   = 1'b0;

        if (tick) begin
            unique case (state)
                IDLE: begin
                    if (sample) begin
                        if (DEB == 8'd1) begin
                            press_now = 1'b1;
                            hold_n    = '0;
                            cnt_n     = '0;
                            state_n   = HELD;
                        end else begin
                            cnt_n   = 8'd1;
                            state_n = PRESS_PEND;
                        end
                    end
                end

                PRESS_PEND: begin
                    if (!sample) begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else if (cnt_inc >= DEB) begin
                        press_now = 1'b1;
                        hold_n    = '0;
                        cnt_n     = '0;
                        state_n   = HELD;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end

                HELD, REPEAT: begin
                    if (!sample) begin
                        from_repeat_n = (state == REPEAT);
                        if (DEB == 8'd1) begin
                            release_now = 1'b1;
                            cnt_n       = '0;
                            hold_n      = '0;
                            state_n     = IDLE;
                        end else begin
                            cnt_n   = 8'd1;
                            state_n = RELEASE_PEND;
                        end
                    end else if (repeat_enable && (hold_inc >= hold_target)) begin
                        press_now = 1'b1;
                        hold_n    = '0;
                        state_n   = REPEAT;
                    end else begin
                        hold_n = hold_inc;
                    end
                end

                RELEASE_PEND: begin
                    if (sample) begin
                        cnt_n   = '0;
                        state_n = from_repeat ? REPEAT : HELD;
                    end else if (cnt_inc >= DEB) begin
                        release_now = 1'b1;
                        cnt_n       = '0;
                        hold_n      = '0;
                        state_n     = IDLE;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end

                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_debounce_repeat.sv
// Key conditioning top: synchronizer, 1 ms tick generator, per-key channels
// and the registered outputs consumed by the game logic.
module key_debounce_repeat
    import key_cond_pkg::*;
#(
    parameter int                clk_mhz          = 27,
    parameter int                n_keys           = 8,
    parameter int                debounce_ms      = 10,
    parameter int                repeat_delay_ms  = 400,
    parameter int                repeat_period_ms = 100,
    parameter logic [n_keys-1:0] repeat_mask      = 8'b1010_0101
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [n_keys-1:0] key_raw,
    output logic [n_keys-1:0] key_level,
    output logic [n_keys-1:0] key_press,
    output logic [n_keys-1:0] key_release,
    output logic              tick
);

    localparam int TICK_CYCLES = ms_to_cycles(clk_mhz);
    localparam int TICK_W      = $clog2(TICK_CYCLES);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_PRE  = TICK_W'(TICK_CYCLES - 2);

    logic [TICK_W-1:0] tick_cnt;
    logic [n_keys-1:0] key_meta;
    logic [n_keys-1:0] key_sync;
    logic [n_keys-1:0] chan_press;
    logic [n_keys-1:0] chan_release;
    logic [n_keys-1:0] chan_level;

    // Two-flop synchronizer bringing the asynchronous key levels into the clock domain.
    always_ff @(posedge clock) begin
        if (reset) begin
            key_meta <= '0;
            key_sync <= '0;
        end else begin
            key_meta <= key_raw;
            key_sync <= key_meta;
        end
    end

    // Free-running millisecond counter; the strobe is registered one step early
    // so that it is high exactly while the counter sits at its last value.
    always_ff @(posedge clock) begin
        if (reset) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
            tick     <= (tick_cnt == TICK_PRE);
        end
    end

    for (genvar i = 0; i < n_keys; i++) begin : g_chan
        key_channel #(
            .debounce_ms      (debounce_ms),
            .repeat_delay_ms  (repeat_delay_ms),
            .repeat_period_ms (repeat_period_ms),
            .repeat_enable    (repeat_mask[i])
        ) u_chan (
            .clock       (clock),
            .reset       (reset),
            .tick        (tick),
            .sample      (key_sync[i]),
            .press_now   (chan_press[i]),
            .release_now (chan_release[i]),
            .level_next  (chan_level[i])
        );
    end

    // Output registers: pulses land the cycle after the deciding tick, level moves with them.
    always_ff @(posedge clock) begin
        if (reset) begin
            key_level   <= '0;
            key_press   <= '0;
            key_release <= '0;
        end else begin
            key_level   <= chan_level;
            key_press   <= chan_press;
            key_release <= chan_release;
        end
    end

endmodule

// File: tb/tb_key_debounce_repeat.sv
// Directed bench for key_debounce_repeat with a 1000-cycle tick,
// debounce of 3 ticks, first repeat after 5 ticks and repeats every 2 ticks.
module tb_key_debounce_repeat;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] key_raw;
    logic [7:0] key_level;
    logic [7:0] key_press;
    logic [7:0] key_release;
    logic       tick;

    int cyc = 0;
    int press_cnt [8];
    int release_cnt [8];
    int both_err = 0;
    int press_t0 [$];
    int check_count = 0;
    int pass_count = 0;

    key_debounce_repeat #(
        .clk_mhz          (1),
        .n_keys           (8),
        .debounce_ms      (3),
        .repeat_delay_ms  (5),
        .repeat_period_ms (2),
        .repeat_mask      (8'b1010_0101)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .tick        (tick)
    );

    // 10 ns clock.
    always #5 clock = ~clock;

    // Cycle counter used for exact pulse spacing.
    always @(posedge clock) cyc <= cyc + 1;

    // Pulse monitor: counts press/release pulses per key and records key 0 press times.
    always @(negedge clock) begin
        for (int i = 0; i < 8; i++) begin
            if (key_press[i] === 1'b1) press_cnt[i]++;
            if (key_release[i] === 1'b1) release_cnt[i]++;
            if ((key_press[i] === 1'b1) && (key_release[i] === 1'b1)) both_err++;
        end
        if (key_press[0] === 1'b1) press_t0.push_back(cyc);
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        check_count++;
        if (actual == expected) pass_count++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    task automatic applyStimulus(input logic [7:0] keys);
        key_raw = keys;
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((tick !== 1'b1) && (n < 1100));
        if (tick !== 1'b1) checkOutput("tick_timeout", 0, 1);
    endtask

    function automatic int pulse_sum();
        int s;
        s = 0;
        for (int i = 0; i < 8; i++) s += press_cnt[i] + release_cnt[i];
        return s;
    endfunction

    initial begin
        int last_cyc;
        int rst_cyc;
        int p0, r0, p7, r7, p5;

        $display("[TB] start");
        reset = 1'b1;
        applyStimulus(8'h00);
        repeat (3) step();
        checkOutput("reset_level",   int'(key_level),   0);
        checkOutput("reset_press",   int'(key_press),   0);
        checkOutput("reset_release", int'(key_release), 0);
        checkOutput("reset_tick",    int'(tick),        0);
        reset = 1'b0;

        // Quiet keys: ticks every 1000 cycles, nothing on the outputs.
        last_cyc = 0;
        for (int i = 0; i < 10; i++) begin
            wait_tick();
            if (i > 0) checkOutput("tick_period", cyc - last_cyc, 1000);
            last_cyc = cyc;
        end
        checkOutput("idle_level",  int'(key_level), 0);
        checkOutput("idle_pulses", pulse_sum(),     0);

        // Keys 1 (no repeat) and 0 (repeat) pressed together right after a tick.
        applyStimulus(8'h03);
        wait_tick();
        wait_tick();
        wait_tick();
        checkOutput("k1_early_press", int'(key_press[1]), 0);
        checkOutput("k1_early_level", int'(key_level[1]), 0);
        step();
        checkOutput("k1_press",       int'(key_press[1]), 1);
        checkOutput("k1_level",       int'(key_level[1]), 1);
        checkOutput("k0_first_press", int'(key_press[0]), 1);
        step();
        checkOutput("k1_press_width", int'(key_press[1]), 0);
        for (int t = 4; t <= 20; t++) wait_tick();
        checkOutput("k0_count_t20", press_cnt[0], 7);
        step();
        checkOutput("k0_repeat_t20", int'(key_press[0]), 1);
        checkOutput("k0_count_final", press_cnt[0], 8);
        checkOutput("k1_count", press_cnt[1], 1);
        checkOutput("k0_times_len", press_t0.size(), 8);
        if (press_t0.size() >= 8) begin
            checkOutput("k0_first_repeat_gap", press_t0[1] - press_t0[0], 5000);
            checkOutput("k0_repeat_gap_a",     press_t0[2] - press_t0[1], 2000);
            checkOutput("k0_repeat_gap_b",     press_t0[7] - press_t0[6], 2000);
        end

        // Release key 0 from REPEAT; the confirming tick is one where a repeat would be due.
        p0 = press_cnt[0];
        r0 = release_cnt[0];
        wait_tick();
        applyStimulus(8'h02);
        wait_tick();
        wait_tick();
        wait_tick();
        checkOutput("k0_release_early", int'(key_release[0]), 0);
        checkOutput("k0_level_pending", int'(key_level[0]),   1);
        step();
        checkOutput("k0_release",        int'(key_release[0]), 1);
        checkOutput("k0_level_low",      int'(key_level[0]),   0);
        checkOutput("k0_repeat_blocked", int'(key_press[0]),   0);
        checkOutput("k0_no_extra_press", press_cnt[0] - p0,    0);
        checkOutput("k0_release_count",  release_cnt[0] - r0,  1);
        checkOutput("k1_still_held",     int'(key_level[1]),   1);

        // Key 7 toggled every tick never qualifies; then a stable press does.
        p7 = press_cnt[7];
        r7 = release_cnt[7];
        for (int i = 0; i < 6; i++) begin
            applyStimulus((i % 2 == 0) ? 8'h82 : 8'h02);
            wait_tick();
        end
        checkOutput("k7_bounce_level",   int'(key_level[7]),  0);
        checkOutput("k7_bounce_press",   press_cnt[7] - p7,   0);
        checkOutput("k7_bounce_release", release_cnt[7] - r7, 0);
        applyStimulus(8'h82);
        wait_tick();
        wait_tick();
        wait_tick();
        checkOutput("k7_early_press", int'(key_press[7]), 0);
        step();
        checkOutput("k7_press",       int'(key_press[7]), 1);
        checkOutput("k7_level",       int'(key_level[7]), 1);
        checkOutput("k7_press_count", press_cnt[7] - p7,  1);

        // Release key 7 and press key 5 together: both events land in one cycle.
        p5 = press_cnt[5];
        applyStimulus(8'h22);
        wait_tick();
        wait_tick();
        wait_tick();
        checkOutput("k7_release_early", int'(key_release[7]), 0);
        checkOutput("k5_press_early",   int'(key_press[5]),   0);
        step();
        checkOutput("k7_release",  int'(key_release[7]), 1);
        checkOutput("k7_level_lo", int'(key_level[7]),   0);
        checkOutput("k5_press",    int'(key_press[5]),   1);
        checkOutput("k5_level",    int'(key_level[5]),   1);
        for (int t = 0; t < 5; t++) wait_tick();
        step();
        checkOutput("k5_repeat",       int'(key_press[5]), 1);
        checkOutput("k5_press_count",  press_cnt[5] - p5,  2);

        // One-cycle reset while key 5 sits in REPEAT; held keys come back as fresh presses.
        repeat (500) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        rst_cyc = cyc;
        checkOutput("midreset_level",   int'(key_level),   0);
        checkOutput("midreset_press",   int'(key_press),   0);
        checkOutput("midreset_release", int'(key_release), 0);
        checkOutput("midreset_tick",    int'(tick),        0);
        wait_tick();
        checkOutput("midreset_first_tick", cyc - rst_cyc, 999);
        wait_tick();
        wait_tick();
        checkOutput("k5_repress_early", int'(key_press[5]), 0);
        checkOutput("k5_level_early",   int'(key_level[5]), 0);
        step();
        checkOutput("k5_repress", int'(key_press[5]), 1);
        checkOutput("k1_repress", int'(key_press[1]), 1);
        checkOutput("k5_relevel", int'(key_level[5]), 1);
        checkOutput("no_release_after_reset", int'(key_release), 0);

        checkOutput("press_release_overlap", both_err, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
